datapath_seq: RTL and testbench

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_seq_if.sv | 11 +
 rtl/datapath_seq.sv | 55 +++++
 tb/tb_datapath_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
// datapath_seq_if: operand request and result handshake channels of datapath_seq
interface datapath_seq_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] res_data;
    logic       res_valid;
    logic       res_ready;
    modport master (output in_data, in_valid, res_ready, input in_ready, res_data, res_valid);
    modport slave (input in_data, in_valid, res_ready, output in_ready, res_data, res_valid);
endinterface

// File: rtl/datapath_seq.sv
// datapath_seq: sequences four operand loads, one compute and a result handoff with idle timeout
module datapath_seq #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic           clock,
    input  logic           rst,
    datapath_seq_if.slave  io,
    output logic           dp_rst_n,
    output logic [3:0]     dp_d_in,
    output logic [3:0]     dp_capture,
    output logic           dp_op,
    input  logic [4:0]     dp_result,
    output logic           err,
    output logic [7:0]     done_cnt
);
    typedef enum logic [2:0] {LD_A, LD_B, LD_C, LD_D, COMPUTE, DONE} state_t;
    state_t state, next, cur;
    logic [7:0] stall;
    logic loading, accept, timeout, xfer;
    // reset forces LD_A behaviour on the outputs in the same cycle it is asserted
    always_comb begin
        cur = rst ? LD_A : state;
        loading = cur inside {LD_A, LD_B, LD_C, LD_D};
        accept = loading & io.in_valid;
        timeout = loading & (cur != LD_A) & ~io.in_valid & (stall == 8'(TIMEOUT_CYC));
        xfer = (cur == DONE) & io.res_ready;
    end
    // state register
    always_ff @(posedge clock)
        state <= rst ? LD_A : next;
    // next-state: operands advance the load chain, timeout aborts to LD_A
    always_comb begin
        next = cur == COMPUTE ? DONE :
               cur == DONE ? (io.res_ready ? LD_A : DONE) :
               timeout ? LD_A :
               accept ? (cur == LD_D ? COMPUTE : state_t'(cur + 3'd1)) : cur;
    end
    // outputs decoded from the effective state
    always_comb begin
        io.in_ready = loading;
        io.res_valid = cur == DONE;
        io.res_data = dp_result;
        dp_capture = accept ? 4'b0001 << cur[1:0] : 4'b0000;
        dp_op = cur == COMPUTE;
        dp_d_in = io.in_data;
        dp_rst_n = ~rst;
        err = timeout;
    end
    // idle-cycle counter between operands, only live in LD_B..LD_D
    always_ff @(posedge clock)
        stall <= (rst | ~loading | (cur == LD_A) | io.in_valid | timeout) ? 8'd0 : stall + 8'd1;
    // count of results handed to the consumer
    always_ff @(posedge clock)
        done_cnt <= rst ? 8'd0 : done_cnt + 8'(xfer);
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed and randomized checks of datapath_seq against a transaction-level model
module tb_datapath_seq;
    logic clk = 0;
    logic rst;
    logic dp_rst_n, dp_op, err;
    logic [3:0] dp_d_in, dp_capture;
    logic [4:0] dp_result;
    logic [7:0] done_cnt;
    logic [3:0] ra, rb, rc, rd;
    logic [7:0] exp_cnt;
    int checks = 0;
    int errors = 0;

    datapath_seq_if io();

    datapath_seq #(.TIMEOUT_CYC(15)) dut (
        .clock(clk), .rst(rst), .io(io), .dp_rst_n(dp_rst_n), .dp_d_in(dp_d_in),
        .dp_capture(dp_capture), .dp_op(dp_op), .dp_result(dp_result), .err(err), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // external datapath: four operand registers and a registered (A+B)-(C+D)
    always @(posedge clk) begin
        if (!dp_rst_n) begin
            ra <= 0; rb <= 0; rc <= 0; rd <= 0; dp_result <= 0;
        end else begin
            if (dp_capture[0]) ra <= dp_d_in;
            if (dp_capture[1]) rb <= dp_d_in;
            if (dp_capture[2]) rc <= dp_d_in;
            if (dp_capture[3]) rd <= dp_d_in;
            if (dp_op) dp_result <= ({1'b0, ra} + {1'b0, rb}) - ({1'b0, rc} + {1'b0, rd});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ref_res(input int a, input int b, input int c, input int d);
        int r;
        r = (a + b) - (c + d);
        return 5'(((r % 32) + 32) % 32);
    endfunction

    task automatic op(input logic [3:0] v, input int idx);
        io.in_valid = 1;
        io.in_data = v;
        @(negedge clk);
        chk("op_ready", io.in_ready, 1);
        chk("op_capture", dp_capture, 1 << idx);
        chk("op_d_in", dp_d_in, v);
        chk("op_err", err, 0);
        @(posedge clk); #1;
        io.in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_capture", dp_capture, 0);
            chk("idle_err", err, 0);
            chk("idle_ready", io.in_ready, 1);
            chk("idle_rv", io.res_valid, 0);
            chk("idle_op", dp_op, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic finish(input logic [4:0] exp, input int hold);
        @(negedge clk);
        chk("compute_op", dp_op, 1);
        chk("compute_ready", io.in_ready, 0);
        chk("compute_rv", io.res_valid, 0);
        @(posedge clk); #1;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_rv", io.res_valid, 1);
            chk("hold_data", io.res_data, exp);
            chk("hold_ready", io.in_ready, 0);
            chk("hold_op", dp_op, 0);
            chk("hold_cnt", done_cnt, exp_cnt);
            @(posedge clk); #1;
        end
        io.res_ready = 1;
        @(negedge clk);
        chk("done_rv", io.res_valid, 1);
        chk("done_data", io.res_data, exp);
        @(posedge clk); #1;
        io.res_ready = 0;
        exp_cnt++;
        @(negedge clk);
        chk("after_rv", io.res_valid, 0);
        chk("after_ready", io.in_ready, 1);
        chk("done_cnt", done_cnt, exp_cnt);
        @(posedge clk); #1;
    endtask

    task automatic seq(input logic [3:0] a, b, c, d, input int hold);
        op(a, 0); op(b, 1); op(c, 2); op(d, 3);
        finish(ref_res(a, b, c, d), hold);
    endtask

    task automatic pulse_rst();
        rst = 1;
        @(negedge clk);
        chk("rst_ready", io.in_ready, 1);
        chk("rst_dp_rst_n", dp_rst_n, 0);
        chk("rst_op", dp_op, 0);
        chk("rst_rv", io.res_valid, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 0;
        exp_cnt = 0;
    endtask

    initial begin
        logic [3:0] v [4];
        rst = 1; io.in_valid = 0; io.in_data = 0; io.res_ready = 0; exp_cnt = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_ready", io.in_ready, 1);
        chk("reset_capture", dp_capture, 0);
        chk("reset_dp_rst_n", dp_rst_n, 0);
        chk("reset_rv", io.res_valid, 0);
        chk("reset_op", dp_op, 0);
        chk("reset_err", err, 0);
        chk("reset_cnt", done_cnt, 0);
        io.in_valid = 1;
        #1;
        chk("reset_capture_valid", dp_capture, 4'b0001);
        @(posedge clk); #1;
        io.in_valid = 0;
        rst = 0;
        seq(3, 5, 2, 4, 0);
        chk("basic_result_cnt", done_cnt, 1);
        seq(1, 1, 4, 4, 0);
        seq(15, 15, 0, 0, 0);
        seq(9, 2, 7, 1, 3);
        op(1, 0); idle(4); op(2, 1); idle(10); op(3, 2); idle(15); op(4, 3);
        finish(ref_res(1, 2, 3, 4), 0);
        op(1, 0); op(2, 1); idle(15);
        @(negedge clk);
        chk("timeout_err", err, 1);
        chk("timeout_ready", io.in_ready, 1);
        chk("timeout_capture", dp_capture, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("timeout_err_clear", err, 0);
        @(posedge clk); #1;
        seq(7, 3, 2, 1, 0);
        op(1, 0); op(2, 1); idle(15); op(9, 2); op(4, 3);
        finish(ref_res(1, 2, 9, 4), 0);
        op(6, 0); op(6, 1); pulse_rst();
        idle(3);
        chk("rst_ldc_cnt", done_cnt, 0);
        seq(8, 8, 3, 3, 1);
        op(1, 0); op(2, 1); op(3, 2); op(4, 3);
        pulse_rst();
        idle(2);
        op(5, 0); op(6, 1); op(7, 2); op(8, 3);
        @(posedge clk); #1;
        pulse_rst();
        idle(3);
        chk("rst_done_cnt", done_cnt, 0);
        seq(12, 1, 0, 5, 0);
        chk("rst_done_after", done_cnt, 1);
        repeat (40) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = 4'($urandom_range(0, 15));
                idle($urandom_range(0, 5));
                op(v[i], i);
            end
            finish(ref_res(v[0], v[1], v[2], v[3]), $urandom_range(0, 3));
        end
        pulse_rst();
        repeat (256) seq(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0);
        chk("wrap_cnt", done_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
